// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: program-memory read port plus the instruction
// handshake/redirect channel shared with the load-store/jump stage.
interface instr_fetch_unit_if;
    logic [7:0] pm_addr;
    logic       pm_rd_en;
    logic [7:0] pm_data;
    logic [7:0] instruction;
    logic [7:0] address;
    logic       instr_valid;
    logic       instr_ready;
    logic       jump_flag;
    logic [7:0] jump_address;

    modport master (
        output pm_addr, pm_rd_en, instruction, address, instr_valid,
        input  pm_data, instr_ready, jump_flag, jump_address
    );

    modport slave (
        input  pm_addr, pm_rd_en, instruction, address, instr_valid,
        output pm_data, instr_ready, jump_flag, jump_address
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Front-end fetch: reads opcode/operand byte pairs from synchronous program
// memory, presents them downstream, follows redirects, halts on HALT_OPCODE.
//
// state    | meaning
// REQ_OP   | issue opcode read at pc
// WAIT_OP  | capture opcode, issue operand read at pc+1
// WAIT_ARG | capture operand, advance pc, raise instr_valid
// ISSUE    | present pair; on handshake prefetch next opcode (jump target or pc)
// HALT     | reserved opcode seen, idle until reset
module instr_fetch_unit #(
    parameter logic [7:0] PC_RESET    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus,
    output logic [7:0]          pc,
    output logic                halted
);
    typedef enum logic [2:0] {
        REQ_OP   = 3'd0,
        WAIT_OP  = 3'd1,
        WAIT_ARG = 3'd2,
        ISSUE    = 3'd3,
        HALT     = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] instruction_q;
    logic [7:0] address_q;
    logic       instr_valid_q;
    logic [7:0] fetch_addr;
    logic       fetch_en;
    logic       handshake;

    assign handshake       = (state == ISSUE) && bus.instr_ready;
    assign bus.pm_addr     = fetch_addr;
    assign bus.pm_rd_en    = fetch_en;
    assign bus.instruction = instruction_q;
    assign bus.address     = address_q;
    assign bus.instr_valid = instr_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ_OP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            REQ_OP:   state_next = WAIT_OP;
            WAIT_OP:  state_next = (bus.pm_data == HALT_OPCODE) ? HALT : WAIT_ARG;
            WAIT_ARG: state_next = ISSUE;
            ISSUE:    state_next = bus.instr_ready ? WAIT_OP : ISSUE;
            HALT:     state_next = HALT;
            default:  state_next = REQ_OP;
        endcase
    end

    // Memory strobe is forced idle while rst is high so no read escapes a reset cycle.
    always_comb begin
        fetch_en   = 1'b0;
        fetch_addr = pc;
        halted     = (state == HALT);
        if (rst) begin
            fetch_addr = PC_RESET;
        end else begin
            unique case (state)
                REQ_OP: begin
                    fetch_en   = 1'b1;
                    fetch_addr = pc;
                end
                WAIT_OP: begin
                    fetch_en   = 1'b1;
                    fetch_addr = pc + 8'd1;
                end
                ISSUE: begin
                    fetch_en   = bus.instr_ready;
                    fetch_addr = (bus.instr_ready && bus.jump_flag) ? bus.jump_address : pc;
                end
                default: begin
                    fetch_en   = 1'b0;
                    fetch_addr = pc;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= PC_RESET;
            instruction_q <= 8'h00;
            address_q     <= 8'h00;
            instr_valid_q <= 1'b0;
        end else begin
            unique case (state)
                WAIT_OP: begin
                    instruction_q <= bus.pm_data;
                end
                WAIT_ARG: begin
                    address_q     <= bus.pm_data;
                    pc            <= pc + 8'd2;
                    instr_valid_q <= 1'b1;
                end
                ISSUE: begin
                    if (handshake) begin
                        pc            <= fetch_addr;
                        instr_valid_q <= 1'b0;
                    end
                end
                default: begin
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic against a cycle-age reference model.
module tb_instr_fetch_unit;
    localparam logic [7:0] PC_RST = 8'h00;
    localparam logic [7:0] HALT_OP = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_v = 1'b1;
    logic       ready_v = 1'b0;
    logic       jf_v = 1'b0;
    logic [7:0] ja_v = 8'h00;
    logic [7:0] pc;
    logic       halted;
    logic [7:0] mem [256];
    int         checks = 0;
    int         errors = 0;

    // Reference model state: cycles since the current pair's opcode read began.
    int         m_age;
    logic [7:0] m_fetch, m_pc, m_instr, m_addr;
    logic       m_halted;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.PC_RESET(PC_RST), .HALT_OPCODE(HALT_OP)) dut (
        .clk    (clk),
        .rst    (rst_v),
        .bus    (bus),
        .pc     (pc),
        .halted (halted)
    );

    assign bus.instr_ready  = ready_v;
    assign bus.jump_flag    = jf_v;
    assign bus.jump_address = ja_v;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.pm_rd_en) bus.pm_data <= mem[bus.pm_addr];
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %02h required %02h", name, act, exp);
        end
    endtask

    task automatic model_check();
        logic       e_rd, e_valid;
        logic [7:0] e_addr;
        if (rst_v) begin
            chk("rst_rd_en", {7'd0, bus.pm_rd_en}, 8'd0);
            chk("rst_pm_addr", bus.pm_addr, PC_RST);
        end else begin
            e_rd = 1'b0; e_valid = 1'b0; e_addr = 8'h00;
            if (!m_halted) begin
                if (m_age == 0) begin
                    e_rd = 1'b1; e_addr = m_fetch;
                end else if (m_age == 1) begin
                    e_rd = 1'b1; e_addr = m_fetch + 8'd1;
                end else if (m_age >= 3) begin
                    e_valid = 1'b1;
                    if (ready_v) begin
                        e_rd = 1'b1; e_addr = jf_v ? ja_v : m_pc;
                    end
                end
            end
            chk("m_rd_en", {7'd0, bus.pm_rd_en}, {7'd0, e_rd});
            if (e_rd) chk("m_pm_addr", bus.pm_addr, e_addr);
            chk("m_valid", {7'd0, bus.instr_valid}, {7'd0, e_valid});
            chk("m_halted", {7'd0, halted}, {7'd0, m_halted});
            chk("m_instruction", bus.instruction, m_instr);
            chk("m_address", bus.address, m_addr);
            chk("m_pc", pc, m_pc);
        end
    endtask

    task automatic model_advance();
        logic [7:0] nxt;
        if (rst_v) begin
            m_age = 0; m_fetch = PC_RST; m_pc = PC_RST;
            m_instr = 8'h00; m_addr = 8'h00; m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m_age == 0) begin
                m_age = 1;
            end else if (m_age == 1) begin
                m_instr = mem[m_fetch];
                if (m_instr == HALT_OP) m_halted = 1'b1;
                else m_age = 2;
            end else if (m_age == 2) begin
                nxt = m_fetch + 8'd1;
                m_addr = mem[nxt];
                m_pc = m_fetch + 8'd2;
                m_age = 3;
            end else if (ready_v) begin
                nxt = jf_v ? ja_v : m_pc;
                m_fetch = nxt; m_pc = nxt; m_age = 1;
            end
        end
    endtask

    // Caller drives inputs at negedge and waits #1 before calling.
    task automatic tick();
        model_check();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic drv(input logic r, input logic rdy, input logic jf, input logic [7:0] ja);
        rst_v = r; ready_v = rdy; jf_v = jf; ja_v = ja;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {1'b0, i[6:0]};
        mem[8'h00] = 8'h0A; mem[8'h01] = 8'h3C;
        mem[8'h02] = 8'h11; mem[8'h03] = 8'h22;
        mem[8'h04] = 8'hFF;
        mem[8'h40] = 8'h5A; mem[8'h41] = 8'h6B;

        drv(1, 0, 0, 8'h00); tick();
        drv(1, 0, 0, 8'h00); tick();

        // reset fetch
        drv(0, 0, 0, 8'h00);
        chk("rf_addr0", bus.pm_addr, 8'h00); chk("rf_rd0", {7'd0, bus.pm_rd_en}, 8'd1);
        chk("rf_instr_rst", bus.instruction, 8'h00); tick();
        drv(0, 0, 0, 8'h00); chk("rf_addr1", bus.pm_addr, 8'h01); tick();
        drv(0, 0, 0, 8'h00); chk("rf_valid_lo", {7'd0, bus.instr_valid}, 8'd0); tick();

        // backpressure, with an ignored jump request in the middle
        for (int c = 0; c < 5; c++) begin
            drv(0, 0, (c == 2), 8'h77);
            chk("bp_valid", {7'd0, bus.instr_valid}, 8'd1);
            chk("bp_rd_en", {7'd0, bus.pm_rd_en}, 8'd0);
            chk("bp_instr", bus.instruction, 8'h0A);
            chk("bp_addr", bus.address, 8'h3C);
            chk("bp_pc", pc, 8'h02);
            tick();
        end
        drv(0, 1, 0, 8'h00);
        chk("rel_pm_addr", bus.pm_addr, 8'h02); chk("rel_rd", {7'd0, bus.pm_rd_en}, 8'd1); tick();
        drv(0, 0, 0, 8'h00); tick();
        drv(0, 0, 0, 8'h00); tick();

        // jump to 40
        drv(0, 1, 1, 8'h40);
        chk("p2_instr", bus.instruction, 8'h11); chk("p2_addr", bus.address, 8'h22);
        chk("p2_pc", pc, 8'h04); chk("jmp_pm_addr", bus.pm_addr, 8'h40); tick();
        drv(0, 0, 0, 8'h00); chk("jmp_pc", pc, 8'h40); tick();
        drv(0, 0, 0, 8'h00); tick();

        // wrap: jump to FF
        mem[8'h00] = 8'h34; mem[8'hFF] = 8'h12;
        drv(0, 1, 1, 8'hFF);
        chk("p3_instr", bus.instruction, 8'h5A); chk("p3_addr", bus.address, 8'h6B);
        chk("p3_pc", pc, 8'h42); tick();
        drv(0, 0, 0, 8'h00); chk("wrap_pm_addr", bus.pm_addr, 8'h00); tick();
        drv(0, 0, 0, 8'h00); tick();

        // halt at 04
        drv(0, 1, 1, 8'h04);
        chk("wrap_instr", bus.instruction, 8'h12); chk("wrap_addr", bus.address, 8'h34);
        chk("wrap_pc", pc, 8'h01); tick();
        drv(0, 1, 0, 8'h00); tick();
        for (int c = 0; c < 5; c++) begin
            drv(0, 1, 1, 8'h20);
            chk("halt_flag", {7'd0, halted}, 8'd1);
            chk("halt_valid", {7'd0, bus.instr_valid}, 8'd0);
            chk("halt_rd_en", {7'd0, bus.pm_rd_en}, 8'd0);
            chk("halt_pc", pc, 8'h04);
            tick();
        end

        // reset from HALT, then reset during WAIT_ARG
        drv(1, 1, 0, 8'h00);
        chk("hrst_rd", {7'd0, bus.pm_rd_en}, 8'd0); chk("hrst_addr", bus.pm_addr, 8'h00); tick();
        drv(0, 0, 0, 8'h00);
        chk("hrst_halted", {7'd0, halted}, 8'd0); chk("hrst_instr", bus.instruction, 8'h00);
        chk("hrst_pc", pc, 8'h00); chk("hrst_rd_en", {7'd0, bus.pm_rd_en}, 8'd1); tick();
        drv(0, 0, 0, 8'h00); tick();
        drv(1, 0, 0, 8'h00); tick();
        drv(0, 0, 0, 8'h00);
        chk("arst_instr", bus.instruction, 8'h00); chk("arst_valid", {7'd0, bus.instr_valid}, 8'd0);
        chk("arst_pc", pc, 8'h00); chk("arst_pm_addr", bus.pm_addr, 8'h00); tick();

        // randomized traffic
        drv(1, 0, 0, 8'h00);
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 29) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        tick();
        for (int c = 0; c < 4000; c++) begin
            drv(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
